// File: rtl/dma_channel_register_file_if.sv
// Host-side register bus of the DMA channel register file: decode strobes,
// channel select, write data and read data.
interface dma_channel_register_file_if;
    logic       loadCommandReg;
    logic       loadModeReg;
    logic       loadBaseAddressReg;
    logic       readCurrentAddressReg;
    logic       ldBaseWordCountReg;
    logic       readCurrentWordCountReg;
    logic       readStatusReg;
    logic       clearInternalFF;
    logic [1:0] chSel;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       dataOutEn;

    modport master (
        output loadCommandReg, loadModeReg, loadBaseAddressReg,
               readCurrentAddressReg, ldBaseWordCountReg,
               readCurrentWordCountReg, readStatusReg, clearInternalFF,
               chSel, dataIn,
        input  dataOut, dataOutEn
    );

    modport slave (
        input  loadCommandReg, loadModeReg, loadBaseAddressReg,
               readCurrentAddressReg, ldBaseWordCountReg,
               readCurrentWordCountReg, readStatusReg, clearInternalFF,
               chSel, dataIn,
        output dataOut, dataOutEn
    );
endinterface

// File: rtl/dma_channel_register_file.sv
// Four-channel DMA register file: command, per-channel mode, base/current
// address and word count, byte-pointer flip-flop, status and per-transfer
// address/count stepping with terminal count and autoinitialize.
module dma_channel_register_file (
    input  logic                              CLK,
    input  logic                              RESET,
    dma_channel_register_file_if.slave        bus,
    input  logic                              xferStep,
    input  logic [1:0]                        xferCh,
    input  logic [3:0]                        reqIn,
    output logic [7:0]                        commandReg,
    output logic [5:0]                        xferMode,
    output logic [15:0]                       xferAddress,
    output logic                              tc
);

    logic        ff_q, ff_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [3:0]  tcFlag_q, tcFlag_d;
    logic        tc_q, tc_d;
    logic [5:0]  mode_q [4];
    logic [5:0]  mode_d [4];
    logic [15:0] baseAddr_q [4];
    logic [15:0] baseAddr_d [4];
    logic [15:0] curAddr_q [4];
    logic [15:0] curAddr_d [4];
    logic [15:0] baseCnt_q [4];
    logic [15:0] baseCnt_d [4];
    logic [15:0] curCnt_q [4];
    logic [15:0] curCnt_d [4];

    logic [3:0]  step_v, term_v, wrAddr_v, wrCnt_v;

    // Per-channel decode of transfer steps, terminal counts and bus writes
    always_comb begin
        step_v   = '0;
        term_v   = '0;
        wrAddr_v = '0;
        wrCnt_v  = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            step_v[c]   = xferStep && (xferCh == 2'(c));
            term_v[c]   = step_v[c] && (curCnt_q[c] == 16'h0000);
            wrAddr_v[c] = bus.loadBaseAddressReg && (bus.chSel == 2'(c));
            wrCnt_v[c]  = bus.ldBaseWordCountReg && (bus.chSel == 2'(c));
        end
    end

    // Next-state for all programmable state, flags and the byte pointer
    always_comb begin
        ff_d = ff_q;
        if (bus.clearInternalFF)
            ff_d = 1'b0;
        else if (bus.loadBaseAddressReg || bus.ldBaseWordCountReg ||
                 bus.readCurrentAddressReg || bus.readCurrentWordCountReg)
            ff_d = ~ff_q;

        cmd_d = bus.loadCommandReg ? bus.dataIn : cmd_q;

        // Status read clears flags first so a same-cycle TC still sets its flag
        tcFlag_d = bus.readStatusReg ? '0 : tcFlag_q;
        tcFlag_d = tcFlag_d | term_v;
        tc_d     = |term_v;

        mode_d     = mode_q;
        baseAddr_d = baseAddr_q;
        curAddr_d  = curAddr_q;
        baseCnt_d  = baseCnt_q;
        curCnt_d   = curCnt_q;

        for (int unsigned c = 0; c < 4; c++) begin
            if (bus.loadModeReg && (bus.dataIn[1:0] == 2'(c)))
                mode_d[c] = bus.dataIn[7:2];

            if (term_v[c] && mode_q[c][4]) begin
                curAddr_d[c] = baseAddr_q[c];
                curCnt_d[c]  = baseCnt_q[c];
            end else if (step_v[c]) begin
                curAddr_d[c] = mode_q[c][5] ? curAddr_q[c] - 16'd1 : curAddr_q[c] + 16'd1;
                curCnt_d[c]  = curCnt_q[c] - 16'd1;
            end

            // A bus write overrides the step for that register only; the
            // unwritten byte keeps its pre-step value.
            if (wrAddr_v[c]) begin
                baseAddr_d[c] = ff_q ? {bus.dataIn, baseAddr_q[c][7:0]} : {baseAddr_q[c][15:8], bus.dataIn};
                curAddr_d[c]  = ff_q ? {bus.dataIn, curAddr_q[c][7:0]}  : {curAddr_q[c][15:8], bus.dataIn};
            end
            if (wrCnt_v[c]) begin
                baseCnt_d[c] = ff_q ? {bus.dataIn, baseCnt_q[c][7:0]} : {baseCnt_q[c][15:8], bus.dataIn};
                curCnt_d[c]  = ff_q ? {bus.dataIn, curCnt_q[c][7:0]}  : {curCnt_q[c][15:8], bus.dataIn};
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ff_q     <= 1'b0;
            cmd_q    <= '0;
            tcFlag_q <= '0;
            tc_q     <= 1'b0;
            for (int unsigned c = 0; c < 4; c++) begin
                mode_q[c]     <= '0;
                baseAddr_q[c] <= '0;
                curAddr_q[c]  <= '0;
                baseCnt_q[c]  <= '0;
                curCnt_q[c]   <= '0;
            end
        end else begin
            ff_q       <= ff_d;
            cmd_q      <= cmd_d;
            tcFlag_q   <= tcFlag_d;
            tc_q       <= tc_d;
            mode_q     <= mode_d;
            baseAddr_q <= baseAddr_d;
            curAddr_q  <= curAddr_d;
            baseCnt_q  <= baseCnt_d;
            curCnt_q   <= curCnt_d;
        end
    end

    // Read data mux driven directly by the read strobes
    always_comb begin
        bus.dataOut   = 8'h00;
        bus.dataOutEn = bus.readCurrentAddressReg || bus.readCurrentWordCountReg ||
                        bus.readStatusReg;
        if (bus.readCurrentAddressReg)
            bus.dataOut = ff_q ? curAddr_q[bus.chSel][15:8] : curAddr_q[bus.chSel][7:0];
        else if (bus.readCurrentWordCountReg)
            bus.dataOut = ff_q ? curCnt_q[bus.chSel][15:8] : curCnt_q[bus.chSel][7:0];
        else if (bus.readStatusReg)
            bus.dataOut = {reqIn, tcFlag_q};
    end

    assign commandReg  = cmd_q;
    assign xferMode    = mode_q[xferCh];
    assign xferAddress = curAddr_q[xferCh];
    assign tc          = tc_q;

endmodule

// File: tb/tb_dma_channel_register_file.sv
// Scoreboard bench for dma_channel_register_file: stimulus pushes expected
// read data and expected output states; a negedge monitor pops and compares.
module tb_dma_channel_register_file;

    localparam int K_CMD  = 0;
    localparam int K_MODE = 1;
    localparam int K_ADDR = 2;
    localparam int K_TC   = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] val;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        xferStep;
    logic [1:0]  xferCh;
    logic [3:0]  reqIn;
    logic [7:0]  commandReg;
    logic [5:0]  xferMode;
    logic [15:0] xferAddress;
    logic        tc;
    logic        chk_en;

    exp_t rd_q[$];
    exp_t st_q[$];
    int   checks = 0;
    int   errors = 0;

    dma_channel_register_file_if bif ();

    dma_channel_register_file dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (bif.slave),
        .xferStep    (xferStep),
        .xferCh      (xferCh),
        .reqIn       (reqIn),
        .commandReg  (commandReg),
        .xferMode    (xferMode),
        .xferAddress (xferAddress),
        .tc          (tc)
    );

    always #5 CLK = ~CLK;

    // Monitor: read data whenever the DUT drives the bus, state on request
    always @(negedge CLK) begin
        exp_t e;
        logic [15:0] act;
        if (bif.dataOutEn) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got %02h with no expectation", bif.dataOut);
            end else begin
                e = rd_q.pop_front();
                if (bif.dataOut !== e.val[7:0]) begin
                    errors++;
                    $display("FAIL %s got %02h expected %02h", e.name, bif.dataOut, e.val[7:0]);
                end
            end
        end
        if (chk_en) begin
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL state_check with empty queue");
            end else begin
                e = st_q.pop_front();
                case (e.kind)
                    K_CMD:   act = {8'h00, commandReg};
                    K_MODE:  act = {10'h000, xferMode};
                    K_ADDR:  act = xferAddress;
                    default: act = {15'h0000, tc};
                endcase
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s got %04h expected %04h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic clr();
        bif.loadCommandReg          = 1'b0;
        bif.loadModeReg             = 1'b0;
        bif.loadBaseAddressReg      = 1'b0;
        bif.readCurrentAddressReg   = 1'b0;
        bif.ldBaseWordCountReg      = 1'b0;
        bif.readCurrentWordCountReg = 1'b0;
        bif.readStatusReg           = 1'b0;
        bif.clearInternalFF         = 1'b0;
        xferStep                    = 1'b0;
        chk_en                      = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        clr();
    endtask

    task automatic expect_st(input int kind, input logic [15:0] val, input string name);
        exp_t e;
        e.name = name; e.kind = kind; e.val = val;
        st_q.push_back(e);
        chk_en = 1'b1;
    endtask

    task automatic check_st(input int kind, input logic [15:0] val, input string name);
        expect_st(kind, val, name);
        tick();
    endtask

    task automatic push_rd(input logic [7:0] val, input string name);
        exp_t e;
        e.name = name; e.kind = 0; e.val = {8'h00, val};
        rd_q.push_back(e);
    endtask

    task automatic wr_cmd(input logic [7:0] d);
        bif.loadCommandReg = 1'b1; bif.dataIn = d; tick();
    endtask

    task automatic wr_mode(input logic [7:0] d);
        bif.loadModeReg = 1'b1; bif.dataIn = d; tick();
    endtask

    task automatic wr_addr(input logic [1:0] ch, input logic [7:0] d);
        bif.loadBaseAddressReg = 1'b1; bif.chSel = ch; bif.dataIn = d; tick();
    endtask

    task automatic wr_cnt(input logic [1:0] ch, input logic [7:0] d);
        bif.ldBaseWordCountReg = 1'b1; bif.chSel = ch; bif.dataIn = d; tick();
    endtask

    task automatic rd_addr(input logic [1:0] ch, input logic [7:0] ex, input string name);
        push_rd(ex, name);
        bif.readCurrentAddressReg = 1'b1; bif.chSel = ch; tick();
    endtask

    task automatic rd_cnt(input logic [1:0] ch, input logic [7:0] ex, input string name);
        push_rd(ex, name);
        bif.readCurrentWordCountReg = 1'b1; bif.chSel = ch; tick();
    endtask

    task automatic rd_stat(input logic [7:0] ex, input string name);
        push_rd(ex, name);
        bif.readStatusReg = 1'b1; tick();
    endtask

    task automatic clr_ff();
        bif.clearInternalFF = 1'b1; tick();
    endtask

    task automatic step(input logic [1:0] ch);
        xferCh = ch; xferStep = 1'b1; tick();
    endtask

    initial begin
        clr();
        bif.chSel  = 2'd0;
        bif.dataIn = 8'h00;
        xferCh     = 2'd0;
        reqIn      = 4'b0000;
        RESET      = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Disturb state, leave the byte pointer on the high byte, then reset mid-cycle
        wr_cmd(8'hFF);
        wr_addr(2'd2, 8'h55);
        check_st(K_CMD, 16'h00FF, "cmd_before_reset");
        RESET = 1'b1;
        expect_st(K_CMD, 16'h0000, "reset_cmd_immediate");
        tick();
        xferCh = 2'd2;
        check_st(K_ADDR, 16'h0000, "reset_ch2_addr");
        check_st(K_TC, 16'h0000, "reset_tc");
        RESET = 1'b0;
        rd_addr(2'd2, 8'h00, "reset_rd_ch2_lo");
        rd_addr(2'd2, 8'h00, "reset_rd_ch2_hi");
        wr_addr(2'd2, 8'h77);
        check_st(K_ADDR, 16'h0077, "reset_ff_low_first");
        wr_addr(2'd2, 8'h00);

        // Channel 1 address programming and read-back
        clr_ff();
        wr_addr(2'd1, 8'h34);
        wr_addr(2'd1, 8'h12);
        rd_addr(2'd1, 8'h34, "ch1_rd_lo");
        rd_addr(2'd1, 8'h12, "ch1_rd_hi");
        rd_addr(2'd1, 8'h34, "ch1_rd_lo_again");
        rd_addr(2'd1, 8'h12, "ch1_rd_hi_again");
        xferCh = 2'd1;
        check_st(K_ADDR, 16'h1234, "ch1_xferAddress");

        // Mode and command writes between the two count bytes leave the pointer alone
        wr_cnt(2'd0, 8'h02);
        wr_mode(8'h96);
        wr_cmd(8'hC4);
        wr_cnt(2'd0, 8'h00);
        check_st(K_CMD, 16'h00C4, "command_C4");
        xferCh = 2'd2;
        check_st(K_MODE, 16'h0025, "mode_ch2");
        rd_cnt(2'd0, 8'h02, "ch0_cnt_lo");
        rd_cnt(2'd0, 8'h00, "ch0_cnt_hi");

        // Count down to terminal count on channel 0
        wr_mode(8'h00);
        step(2'd0);
        rd_cnt(2'd0, 8'h01, "ch0_cnt1_lo");
        rd_cnt(2'd0, 8'h00, "ch0_cnt1_hi");
        step(2'd0);
        rd_cnt(2'd0, 8'h00, "ch0_cnt0_lo");
        rd_cnt(2'd0, 8'h00, "ch0_cnt0_hi");
        xferCh = 2'd0; xferStep = 1'b1;
        expect_st(K_TC, 16'h0000, "tc_low_before_terminal");
        tick();
        check_st(K_TC, 16'h0001, "tc_pulse_ch0");
        check_st(K_TC, 16'h0000, "tc_one_cycle");
        check_st(K_ADDR, 16'h0003, "ch0_addr_after_3");
        rd_cnt(2'd0, 8'hFF, "ch0_wrap_lo");
        rd_cnt(2'd0, 8'hFF, "ch0_wrap_hi");
        reqIn = 4'b1010;
        rd_stat(8'hA1, "status_tc0");
        rd_stat(8'hA0, "status_cleared");

        // Autoinitialize with decrement on channel 3, then without autoinit
        clr_ff();
        wr_addr(2'd3, 8'h00);
        wr_addr(2'd3, 8'h00);
        wr_cnt(2'd3, 8'h00);
        wr_cnt(2'd3, 8'h00);
        wr_mode(8'hC3);
        step(2'd3);
        check_st(K_TC, 16'h0001, "tc_autoinit");
        check_st(K_ADDR, 16'h0000, "autoinit_addr_reload");
        rd_cnt(2'd3, 8'h00, "autoinit_cnt_lo");
        rd_cnt(2'd3, 8'h00, "autoinit_cnt_hi");
        wr_mode(8'h83);
        step(2'd3);
        check_st(K_TC, 16'h0001, "tc_no_autoinit");
        check_st(K_ADDR, 16'hFFFF, "decrement_wrap_addr");
        rd_stat(8'hA8, "status_tc3");
        rd_stat(8'hA0, "status_cleared2");

        // Status read in the same cycle a terminal count sets the flag
        wr_cnt(2'd3, 8'h00);
        wr_cnt(2'd3, 8'h00);
        push_rd(8'hA0, "status_same_cycle_tc");
        xferCh = 2'd3; xferStep = 1'b1; bif.readStatusReg = 1'b1;
        tick();
        rd_stat(8'hA8, "status_flag_survives");
        check_st(K_ADDR, 16'hFFFE, "ch3_addr_decrement");

        // Bus write to the high address byte collides with a step on channel 2
        clr_ff();
        wr_cnt(2'd2, 8'h05);
        wr_cnt(2'd2, 8'h00);
        wr_addr(2'd2, 8'hFF);
        xferCh = 2'd2; xferStep = 1'b1;
        bif.loadBaseAddressReg = 1'b1; bif.chSel = 2'd2; bif.dataIn = 8'hAB;
        tick();
        check_st(K_ADDR, 16'hABFF, "collision_addr");
        rd_cnt(2'd2, 8'h04, "collision_cnt_lo");
        rd_cnt(2'd2, 8'h00, "collision_cnt_hi");

        repeat (2) tick();
        checks++;
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d pending expected 0/0", rd_q.size(), st_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_channel_register_file.md
# dma_channel_register_file

Four-channel register file for the DMA controller, directly downstream of the register-code decoder. It consumes the one-cycle decode strobes plus the 8-bit data bus and holds all programmable state: command, per-channel mode, and base/current address and word-count registers. It implements the byte-pointer flip-flop, returns read data and status, and applies per-transfer address/count updates, terminal count and autoinitialize for the transfer engine.

## Interface
- No parameters; 4 channels, 16-bit address/count, 8-bit data bus are fixed.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- loadCommandReg, loadModeReg, loadBaseAddressReg, readCurrentAddressReg, ldBaseWordCountReg, readCurrentWordCountReg, readStatusReg, clearInternalFF  in  1 each  decode strobes; each asserted cycle is one bus access; at most one high per cycle.
- chSel  in  2  channel for address/count accesses ({A2,A1}).
- dataIn  in  8  write data bus.
- dataOut  out  8  read data (combinational from strobes and state).
- dataOutEn  out  1  high when any read strobe is high.
- xferStep  in  1  one transfer completed on channel xferCh this cycle.
- xferCh  in  2  channel being serviced.
- reqIn  in  4  channel request lines, reflected in status.
- commandReg  out  8  command register.
- xferMode  out  6  mode of xferCh: [5] address decrement, [4] autoinit, [3:2] transfer type, [1:0] transfer mode.
- xferAddress  out  16  current address of xferCh.
- tc  out  1  one-cycle terminal-count pulse.

## Operation
- Byte-pointer FF: 0 selects low byte, 1 high byte. Toggles after every loadBaseAddressReg, ldBaseWordCountReg, readCurrentAddressReg and readCurrentWordCountReg. clearInternalFF forces 0.
- Address/count write: selected byte of base AND current register of chSel loaded from dataIn; other byte unchanged.
- Address/count read: dataOut = selected byte of current register of chSel.
- Mode write: dataIn[1:0] selects channel; mode[ch] <= dataIn[7:2]. FF unaffected.
- Command write: commandReg <= dataIn.
- Status read: dataOut = {reqIn[3:0], tcFlag[3:0]}; all tcFlag cleared at that edge.
- dataOut = 8'h00 when no read strobe.
- xferStep on channel c: currentAddress[c] +1 (mode[5]=0) or -1 (mode[5]=1), modulo 2^16. currentCount[c] -1, modulo 2^16.
- Terminal count: xferStep when currentCount[c] == 16'h0000 (the decrement wraps to FFFF). Then: tc=1 for one cycle, tcFlag[c]=1. If mode[c][4]=1, current address and count reload from base instead of stepping.
- Count programmed N gives N+1 transfers before tc.

## Timing
- RESET (async): commandReg, all mode, base/current registers, tcFlag, FF = 0; tc = 0. dataOut = 0 and dataOutEn = 0 while strobes are low.
- Writes visible on outputs the cycle after the strobe edge. Read data is valid in the strobe cycle; the FF toggles at the end of that cycle.
- xferStep result is visible on xferAddress next cycle. tc is registered and high in the cycle after the terminal step.
- Bus write to current address/count of channel c plus xferStep on c in the same cycle: the write wins for the written byte. The other byte keeps its pre-step value, and that register is not stepped. The other register (address vs count) still steps.
- Status read in the same cycle as a TC set on channel c: tcFlag[c] ends at 1; other flags clear.
- clearInternalFF in the same cycle as FF-toggling access: cannot occur (strobes exclusive).
- RESET mid-sequence, e.g. after the low byte only: FF returns to 0; the next write targets the low byte.

## Test plan
- Reset: assert RESET mid-cycle → all outputs 0 immediately; read ch2 current address → 00, 00.
- Program ch1 address: clearInternalFF, write 34 then 12 with chSel=01 → base and current = 16'h1234; two reads return 34, 12; FF back to 0.
- Count/TC: ch0 count=0002, mode=000000, three xferSteps on ch0 → count 0001, 0000, FFFF. tc pulses once after the third step. Status read returns xxxx0001, then the next read returns xxxx0000.
- Autoinit + decrement: ch3 base addr=0000, count=0000, mode[5:4]=11 → first step wraps count and reloads. xferAddress stays 0000, tc=1. Without autoinit, address → FFFF.
- Collision: ch2 current addr 00FF, high-byte write 0xAB with simultaneous xferStep on ch2 → address 16'hABFF, count still decrements.
- Mode/command: write command 0xC4 and mode byte 0x96 (ch2 ← 100101) → commandReg=C4; xferCh=2 gives xferMode=6'b100101; FF unchanged.
